calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Multi-digit calculator sequencer that sits between the keypad decoder and the result display. It accumulates decimal operands from key pulses and latches the operator. On '=' it runs a multi-cycle arithmetic operation: single-cycle add/sub, iterative shift-add multiply, restoring divide. It then presents the result, with busy/valid/error status, and supports chaining from a previous result.

## Interface
- WIDTH, 16, unsigned operand/result width (≥4)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clock clk
- key_valid  input  1  one-cycle pulse, key_code valid this cycle
- key_code  input  4  0–9 digit; 10 '+'; 11 '-'; 12 '*'; 13 '/'; 14 '='; 15 clear
- display  output  WIDTH  value to show (current entry or result)
- result  output  WIDTH  last completed result, held until next completion/clear
- result_valid  output  1  one-cycle pulse on completion
- busy  output  1  high while an operation executes
- error  output  1  sticky error flag, cleared only by clear key or reset

## Operation
- Registers: a, b (WIDTH), op (2b), b_seen (1b), iteration counter (log2(WIDTH)+1 b), working regs for mul/div.
- States: ENTER_A, ENTER_B, EXEC, RESULT, ERROR. Reset → ENTER_A, all registers and outputs 0.
- Clear key (15): accepted in every state, including EXEC. Zeroes a, b, result, error, and aborts any operation → ENTER_A.
- Digit entry: reg ← reg*10 + d, computed at WIDTH+4 bits. If the value exceeds 2^WIDTH−1, the digit is ignored and the register is unchanged.
- ENTER_A: digit → accumulate into a. Operator → latch op, b←0, b_seen←0 → ENTER_B. '=' ignored.
- ENTER_B:
  - digit → accumulate into b, b_seen←1.
  - operator with b_seen=0 → replaces op. Operator with b_seen=1 → ignored.
  - '=' with b_seen=1 → EXEC, counter loaded. '=' with b_seen=0 → ignored.
- EXEC (busy=1): all keys except clear are dropped, not queued.
  - add: a+b; carry out → ERROR.
  - sub: a−b; a<b → ERROR.
  - mul: shift-add over WIDTH iterations, 2·WIDTH-bit product; any upper-half bit set → ERROR.
  - div: restoring over WIDTH iterations, quotient only; b=0 → ERROR in the first EXEC cycle, no iterations.
- RESULT: result holds the value. Digit d → a←d → ENTER_A. Operator → a←result, latch op, b←0, b_seen←0 → ENTER_B (chaining). '=' ignored.
- ERROR: error=1, result unchanged, result_valid never pulses. Only clear exits.
- display by state:
  - ENTER_A: a
  - ENTER_B: b if b_seen, else a
  - EXEC: b
  - RESULT: result
  - ERROR: 0

## Timing
- key_valid/key_code are sampled at the rising edge. The state update is visible the following cycle.
- '=' sampled at edge N: EXEC occupies cycle N→N+1; busy is high from N to the EXEC exit edge.
- add/sub: one EXEC cycle. RESULT is entered at edge N+1, and result_valid/result update in cycle N+1→N+2.
- mul/div: exactly WIDTH EXEC cycles. RESULT entered at edge N+WIDTH, with result_valid high for that single cycle.
- Div-by-zero/overflow/underflow: ERROR entered at the EXEC exit edge (N+1 for div-by-zero and add/sub; N+WIDTH for mul overflow). error rises in the same cycle busy falls.
- Clear sampled at edge M: by cycle M→M+1, busy=0, error=0, result=0, display=0.
- Reset mid-EXEC: all outputs 0 asynchronously, state ENTER_A, no result_valid pulse.
- key_valid in the RESULT cycle is processed normally (chaining works back-to-back).

## Test plan
- 1,2,+,3,4,= → display 12 then 34; result=46, result_valid pulse 1 cycle, 1 cycle busy, error 0.
- 2,5,5,*,2,5,7,= → busy exactly 16 cycles, result=65535. Then clear, 2,5,6,*,2,5,6,= → error=1 after 16 cycles, no result_valid.
- 1,0,0,/,7,= → result=14 after 16 busy cycles. 5,/,0,= → error after 1 EXEC cycle; digits ignored until clear.
- 3,-,5,= → error=1. 6,5,5,3,6 in ENTER_A → display stays 6553.
- 6,*,7,= → 42, then +,8,= → 50. A digit key pressed during busy is dropped (result unchanged by it). '+','-' in ENTER_B before digits → op becomes subtract.
- Reset pulse at 8th multiply cycle → all outputs 0 immediately. 4,+,1,= afterwards → result=5.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-driven decimal operand entry and
// multi-cycle add/sub/mul/div sequencer with chaining.
module calc_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [WIDTH-1:0] display,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             error
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_EXEC,
    S_RESULT,
    S_ERROR
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   a, b;
  logic [1:0]         op;
  logic               b_seen;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand, prod;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   quot, rem;

  logic is_digit, is_op, is_eq, is_clr;
  logic [WIDTH-1:0]   acc_src;
  logic [WIDTH+3:0]   acc_ext;
  logic               acc_fits;
  logic [WIDTH:0]     add_ext;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     rem_sh, rem_dif;
  logic               rem_ge;
  logic [WIDTH-1:0]   quot_nx;
  logic               last;
  logic               exec_done, exec_fail;
  logic [WIDTH-1:0]   exec_val;

  // Key decode, digit accumulation and arithmetic step terms
  always_comb begin
    is_digit = key_valid && (key_code < 4'd10);
    is_op    = key_valid && (key_code >= 4'd10)
               && (key_code <= 4'd13);
    is_eq    = key_valid && (key_code == 4'd14);
    is_clr   = key_valid && (key_code == 4'd15);
    acc_src  = (state == S_ENTER_B) ? b : a;
    acc_ext  = {4'b0, acc_src} * (WIDTH+4)'(10)
               + (WIDTH+4)'(key_code);
    acc_fits = (acc_ext[WIDTH+3:WIDTH] == 4'd0);
    add_ext  = {1'b0, a} + {1'b0, b};
    mul_sum  = prod + (mplier[0] ? mcand : '0);
    rem_sh   = {rem, quot[WIDTH-1]};
    rem_dif  = rem_sh - {1'b0, b};
    rem_ge   = ~rem_dif[WIDTH];
    quot_nx  = {quot[WIDTH-2:0], rem_ge};
    last     = (cnt == CW'(1));
  end

  // Completion and failure of the operation in flight
  always_comb begin
    exec_done = 1'b0;
    exec_fail = 1'b0;
    exec_val  = '0;
    unique case (op)
      OP_ADD: begin
        exec_done = 1'b1;
        exec_fail = add_ext[WIDTH];
        exec_val  = add_ext[WIDTH-1:0];
      end
      OP_SUB: begin
        exec_done = 1'b1;
        exec_fail = (a < b);
        exec_val  = a - b;
      end
      OP_MUL: begin
        exec_done = last;
        exec_fail = last && (|mul_sum[2*WIDTH-1:WIDTH]);
        exec_val  = mul_sum[WIDTH-1:0];
      end
      default: begin
        if (b == '0) begin
          exec_done = 1'b1;
          exec_fail = 1'b1;
        end else begin
          exec_done = last;
        end
        exec_val = quot_nx;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_ENTER_A;
    else       state <= state_nx;
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_nx = state;
    if (is_clr) begin
      state_nx = S_ENTER_A;
    end else begin
      unique case (state)
        S_ENTER_A: if (is_op) state_nx = S_ENTER_B;
        S_ENTER_B: if (is_eq && b_seen) state_nx = S_EXEC;
        S_EXEC: if (exec_done)
          state_nx = exec_fail ? S_ERROR : S_RESULT;
        S_RESULT: begin
          if (is_digit)   state_nx = S_ENTER_A;
          else if (is_op) state_nx = S_ENTER_B;
        end
        default: state_nx = state;
      endcase
    end
  end

  // Status outputs and display selection
  always_comb begin
    busy  = (state == S_EXEC);
    error = (state == S_ERROR);
    unique case (state)
      S_ENTER_A: display = a;
      S_ENTER_B: display = b_seen ? b : a;
      S_EXEC:    display = b;
      S_RESULT:  display = result;
      default:   display = '0;
    endcase
  end

  // Operand, operator, working and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      op <= '0;
      b_seen <= 1'b0;
      cnt <= '0;
      mcand <= '0;
      prod <= '0;
      mplier <= '0;
      quot <= '0;
      rem <= '0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (is_clr) begin
        a <= '0;
        b <= '0;
        op <= '0;
        b_seen <= 1'b0;
        cnt <= '0;
        result <= '0;
      end else begin
        unique case (state)
          S_ENTER_A: begin
            if (is_digit && acc_fits)
              a <= acc_ext[WIDTH-1:0];
            if (is_op) begin
              op <= key_code[1:0];
              b <= '0;
              b_seen <= 1'b0;
            end
          end
          S_ENTER_B: begin
            if (is_digit) begin
              if (acc_fits) b <= acc_ext[WIDTH-1:0];
              b_seen <= 1'b1;
            end
            if (is_op && !b_seen) op <= key_code[1:0];
            if (is_eq && b_seen) begin
              cnt <= CNT_INIT;
              mcand <= {{WIDTH{1'b0}}, a};
              prod <= '0;
              mplier <= b;
              quot <= a;
              rem <= '0;
            end
          end
          S_EXEC: begin
            cnt <= cnt - CW'(1);
            mcand <= mcand << 1;
            prod <= mul_sum;
            mplier <= mplier >> 1;
            quot <= quot_nx;
            rem <= rem_ge ? rem_dif[WIDTH-1:0]
                          : rem_sh[WIDTH-1:0];
            if (exec_done && !exec_fail) begin
              result <= exec_val;
              result_valid <= 1'b1;
            end
          end
          S_RESULT: begin
            if (is_digit) begin
              a <= {{(WIDTH-4){1'b0}}, key_code};
            end else if (is_op) begin
              a <= result;
              op <= key_code[1:0];
              b <= '0;
              b_seen <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed scenario tests for the
// calculator sequencer with hand-computed expectations.
module tb_calc_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic [3:0]   key_code;
  logic [W-1:0] display;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic         error;

  int tests = 0;
  int fails = 0;

  calc_sequencer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .display(display),
    .result(result),
    .result_valid(result_valid),
    .busy(busy),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 4'd0;
  endtask

  task automatic run_eq(output int bc, output int rvc);
    bc = 0;
    rvc = 0;
    press(4'd14);
    for (int i = 0; i < 24; i++) begin
      if (busy) bc++;
      if (result_valid) rvc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 4'd0;
    #12;
    tests++;
    if (display !== '0 || result !== '0) begin
      fails++;
      $display("FAIL reset_data: display=%0d result=%0d expected 0 0",
               display, result);
    end
    tests++;
    if (busy !== 1'b0 || error !== 1'b0 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: busy=%b error=%b rv=%b expected 000",
               busy, error, result_valid);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add;
    int bc, rvc;
    press(4'd15);
    press(4'd1); press(4'd2);
    tests++;
    if (display !== 16'd12) begin
      fails++;
      $display("FAIL add_entry_a: display=%0d expected 12", display);
    end
    press(4'd10);
    tests++;
    if (display !== 16'd12) begin
      fails++;
      $display("FAIL add_op_display: display=%0d expected 12", display);
    end
    press(4'd3); press(4'd4);
    tests++;
    if (display !== 16'd34) begin
      fails++;
      $display("FAIL add_entry_b: display=%0d expected 34", display);
    end
    run_eq(bc, rvc);
    tests++;
    if (result !== 16'd46 || display !== 16'd46) begin
      fails++;
      $display("FAIL add_result: result=%0d display=%0d expected 46",
               result, display);
    end
    tests++;
    if (bc != 1 || rvc != 1 || error !== 1'b0) begin
      fails++;
      $display("FAIL add_timing: busy=%0d rv=%0d err=%b expected 1 1 0",
               bc, rvc, error);
    end
  endtask

  task automatic test_mul;
    int bc, rvc;
    press(4'd15);
    press(4'd2); press(4'd5); press(4'd5);
    press(4'd12);
    press(4'd2); press(4'd5); press(4'd7);
    run_eq(bc, rvc);
    tests++;
    if (result !== 16'd65535 || error !== 1'b0) begin
      fails++;
      $display("FAIL mul_result: result=%0d err=%b expected 65535 0",
               result, error);
    end
    tests++;
    if (bc != 16 || rvc != 1) begin
      fails++;
      $display("FAIL mul_timing: busy=%0d rv=%0d expected 16 1", bc, rvc);
    end
    press(4'd15);
    tests++;
    if (result !== '0 || display !== '0 || error !== 1'b0) begin
      fails++;
      $display("FAIL clear: result=%0d display=%0d err=%b expected 0 0 0",
               result, display, error);
    end
    press(4'd2); press(4'd5); press(4'd6);
    press(4'd12);
    press(4'd2); press(4'd5); press(4'd6);
    run_eq(bc, rvc);
    tests++;
    if (error !== 1'b1 || bc != 16 || rvc != 0) begin
      fails++;
      $display("FAIL mul_ovf: err=%b busy=%0d rv=%0d expected 1 16 0",
               error, bc, rvc);
    end
    tests++;
    if (result !== '0 || display !== '0) begin
      fails++;
      $display("FAIL mul_ovf_out: result=%0d display=%0d expected 0 0",
               result, display);
    end
  endtask

  task automatic test_div;
    int bc, rvc;
    press(4'd15);
    press(4'd1); press(4'd0); press(4'd0);
    press(4'd13);
    press(4'd7);
    run_eq(bc, rvc);
    tests++;
    if (result !== 16'd14 || bc != 16 || rvc != 1) begin
      fails++;
      $display("FAIL div_result: result=%0d busy=%0d rv=%0d expected 14 16 1",
               result, bc, rvc);
    end
    press(4'd15);
    press(4'd5); press(4'd13); press(4'd0);
    run_eq(bc, rvc);
    tests++;
    if (error !== 1'b1 || bc != 1 || rvc != 0) begin
      fails++;
      $display("FAIL div_zero: err=%b busy=%0d rv=%0d expected 1 1 0",
               error, bc, rvc);
    end
    press(4'd3);
    tests++;
    if (error !== 1'b1 || display !== '0) begin
      fails++;
      $display("FAIL err_sticky: err=%b display=%0d expected 1 0",
               error, display);
    end
    press(4'd15);
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: err=%b expected 0", error);
    end
  endtask

  task automatic test_sub_and_entry;
    int bc, rvc;
    press(4'd15);
    press(4'd3); press(4'd11); press(4'd5);
    run_eq(bc, rvc);
    tests++;
    if (error !== 1'b1 || rvc != 0) begin
      fails++;
      $display("FAIL sub_under: err=%b rv=%0d expected 1 0", error, rvc);
    end
    press(4'd15);
    press(4'd6); press(4'd5); press(4'd5); press(4'd3); press(4'd6);
    tests++;
    if (display !== 16'd6553) begin
      fails++;
      $display("FAIL entry_ovf: display=%0d expected 6553", display);
    end
  endtask

  task automatic test_chain;
    int bc, rvc;
    press(4'd15);
    press(4'd6); press(4'd12); press(4'd7);
    run_eq(bc, rvc);
    tests++;
    if (result !== 16'd42) begin
      fails++;
      $display("FAIL chain_mul: result=%0d expected 42", result);
    end
    press(4'd10);
    tests++;
    if (display !== 16'd42) begin
      fails++;
      $display("FAIL chain_a: display=%0d expected 42", display);
    end
    press(4'd8);
    run_eq(bc, rvc);
    tests++;
    if (result !== 16'd50 || bc != 1 || rvc != 1) begin
      fails++;
      $display("FAIL chain_add: result=%0d busy=%0d rv=%0d expected 50 1 1",
               result, bc, rvc);
    end
  endtask

  task automatic test_busy_drop;
    press(4'd15);
    press(4'd6); press(4'd12); press(4'd7);
    press(4'd14);
    press(4'd5);
    repeat (20) @(negedge clk);
    tests++;
    if (result !== 16'd42 || display !== 16'd42 || busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_drop: result=%0d display=%0d busy=%b expected 42 42 0",
               result, display, busy);
    end
  endtask

  task automatic test_op_replace;
    int bc, rvc;
    press(4'd15);
    press(4'd9); press(4'd10); press(4'd11); press(4'd4);
    run_eq(bc, rvc);
    tests++;
    if (result !== 16'd5 || rvc != 1) begin
      fails++;
      $display("FAIL op_replace: result=%0d rv=%0d expected 5 1",
               result, rvc);
    end
  endtask

  task automatic test_reset_mid_exec;
    int bc, rvc;
    press(4'd2); press(4'd12); press(4'd3);
    press(4'd14);
    repeat (7) @(negedge clk);
    tests++;
    if (busy !== 1'b1 || result !== 16'd5) begin
      fails++;
      $display("FAIL pre_reset: busy=%b result=%0d expected 1 5",
               busy, result);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || display !== '0 || result !== '0
        || error !== 1'b0 || result_valid !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: busy=%b disp=%0d res=%0d err=%b rv=%b expected all 0",
               busy, display, result, error, result_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    rvc = 0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) rvc++;
      @(negedge clk);
    end
    tests++;
    if (rvc != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: rv=%0d busy=%b expected 0 0", rvc, busy);
    end
    press(4'd4); press(4'd10); press(4'd1);
    run_eq(bc, rvc);
    tests++;
    if (result !== 16'd5 || bc != 1 || rvc != 1) begin
      fails++;
      $display("FAIL post_reset: result=%0d busy=%0d rv=%0d expected 5 1 1",
               result, bc, rvc);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_sub_and_entry();
    test_chain();
    test_busy_drop();
    test_op_replace();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
